jump_sequencer: RTL and testbench

- Frame-rate FSM that sequences the sprite's vertical-motion airtime counter and produces the signed vertical velocity for the sprite position logic.
- Sits between the keyboard/collision logic and the airtime counter.
- Drives the counter's enable, clear and gravity-preload controls.
- Decides launch, apex hang, fall and landing once per video frame.

---
 rtl/jump_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_jump_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jump_sequencer.sv
// jump_sequencer: once-per-frame vertical-motion FSM. Decides launch, apex
// hang, fall and landing, produces the signed vertical velocity and drives
// the airtime counter's enable / clear / gravity-preload controls.
//
// Handshake: there is no valid/ready flow here. frame_tick is a one-cycle
// strobe; every state/velocity update happens only on a cycle where it is
// high, and count_en, cnt_clr, jump_ack and landed are registered
// one-cycle pulses appearing the cycle after the tick that caused them.
module jump_sequencer #(
    parameter int CNT_W        = 11,
    parameter int VEL_W        = 5,
    parameter int JUMP_VEL     = 8,
    parameter int RISE_FRAMES  = 16,
    parameter int APEX_FRAMES  = 4,
    parameter int MAX_FALL_VEL = 8
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    frame_tick,
    input  logic                    jump_req,
    input  logic                    on_ground,
    input  logic [CNT_W-1:0]        count_in,
    output logic                    count_en,
    output logic                    cnt_clr,
    output logic                    pure_grav,
    output logic signed [VEL_W-1:0] vel_y,
    output logic [1:0]              state,
    output logic                    jump_ack,
    output logic                    landed
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        APEX   = 2'd2,
        FALL   = 2'd3
    } state_t;

    // frame counter must hold the longer of the two timed phases
    localparam int FC_MAX = (RISE_FRAMES > APEX_FRAMES) ? RISE_FRAMES : APEX_FRAMES;
    localparam int FC_W   = $clog2(FC_MAX) + 1;

    localparam logic [FC_W-1:0]         RISE_LAST = FC_W'(RISE_FRAMES - 1);
    localparam logic [FC_W-1:0]         APEX_LAST = FC_W'(APEX_FRAMES - 1);
    localparam logic signed [VEL_W-1:0] NEG_JUMP  = VEL_W'(-JUMP_VEL);
    localparam logic signed [VEL_W-1:0] MINUS_ONE = VEL_W'(-1);
    localparam logic signed [VEL_W-1:0] ONE_V     = VEL_W'(1);
    localparam logic signed [VEL_W-1:0] MAX_V     = VEL_W'(MAX_FALL_VEL);
    localparam logic signed [VEL_W:0]   MAX_WIDE  = (VEL_W + 1)'(MAX_FALL_VEL);

    state_t                  state_q, state_nxt;
    logic signed [VEL_W-1:0] vel_q, vel_nxt;
    logic [FC_W-1:0]         fc_q, fc_nxt;
    logic                    pending_q, pending_nxt;
    logic                    jump_q;
    logic                    en_q, en_nxt;
    logic                    clr_q, clr_nxt;
    logic                    ack_q, ack_nxt;
    logic                    land_q, land_nxt;

    logic                    jump_edge;
    logic                    launch_req;
    logic                    overflow;
    logic signed [VEL_W:0]   vel_ext;
    logic signed [VEL_W:0]   vel_inc;
    logic signed [VEL_W-1:0] vel_inc_sat;
    logic signed [VEL_W-1:0] rise_vel;

    assign jump_edge  = jump_req & ~jump_q;
    // an edge coinciding with the tick launches without waiting for pending
    assign launch_req = pending_q | jump_edge;
    assign overflow   = &count_in;

    // one-step increment computed one bit wider so it can never wrap
    assign vel_ext     = {vel_q[VEL_W-1], vel_q};
    assign vel_inc     = vel_ext + (VEL_W + 1)'(1);
    assign vel_inc_sat = (vel_inc > MAX_WIDE) ? MAX_V : vel_inc[VEL_W-1:0];
    // releasing the key while still rising fast cuts the jump short
    assign rise_vel    = (!jump_req && (vel_q < MINUS_ONE)) ? MINUS_ONE : vel_inc_sat;

    // registered state, velocity, press capture and output pulses
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= GROUND;
            vel_q     <= '0;
            fc_q      <= '0;
            pending_q <= 1'b0;
            jump_q    <= 1'b0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            ack_q     <= 1'b0;
            land_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            vel_q     <= vel_nxt;
            fc_q      <= fc_nxt;
            pending_q <= pending_nxt;
            jump_q    <= jump_req;
            en_q      <= en_nxt;
            clr_q     <= clr_nxt;
            ack_q     <= ack_nxt;
            land_q    <= land_nxt;
        end
    end

    // next-state, velocity and pulse decode, evaluated only on frame ticks
    always_comb begin
        state_nxt   = state_q;
        vel_nxt     = vel_q;
        fc_nxt      = fc_q;
        en_nxt      = 1'b0;
        clr_nxt     = 1'b0;
        ack_nxt     = 1'b0;
        land_nxt    = 1'b0;
        pending_nxt = pending_q;

        // presses are only remembered on the ground; every tick consumes them
        if (frame_tick) begin
            pending_nxt = 1'b0;
        end else if (jump_edge && (state_q == GROUND)) begin
            pending_nxt = 1'b1;
        end

        if (frame_tick) begin
            case (state_q)
                GROUND: begin
                    vel_nxt = '0;
                    if (launch_req && on_ground) begin
                        state_nxt = RISE;
                        vel_nxt   = NEG_JUMP;
                        fc_nxt    = '0;
                        clr_nxt   = 1'b1;
                        ack_nxt   = 1'b1;
                    end else if (!on_ground) begin
                        // walked off a ledge
                        state_nxt = FALL;
                        vel_nxt   = ONE_V;
                        clr_nxt   = 1'b1;
                    end
                end
                RISE: begin
                    en_nxt = 1'b1;
                    if (overflow) begin
                        state_nxt = FALL;
                        vel_nxt   = MAX_V;
                        fc_nxt    = '0;
                    end else if ((rise_vel == '0) || (fc_q == RISE_LAST)) begin
                        state_nxt = APEX;
                        vel_nxt   = '0;
                        fc_nxt    = '0;
                    end else begin
                        vel_nxt = rise_vel;
                        fc_nxt  = fc_q + FC_W'(1);
                    end
                end
                APEX: begin
                    en_nxt  = 1'b1;
                    vel_nxt = '0;
                    if (overflow) begin
                        state_nxt = FALL;
                        vel_nxt   = MAX_V;
                        fc_nxt    = '0;
                    end else if (fc_q == APEX_LAST) begin
                        state_nxt = FALL;
                        vel_nxt   = ONE_V;
                        fc_nxt    = '0;
                    end else begin
                        fc_nxt = fc_q + FC_W'(1);
                    end
                end
                FALL: begin
                    // landing beats the overflow clamp and suppresses count_en
                    if (on_ground) begin
                        state_nxt = GROUND;
                        vel_nxt   = '0;
                        land_nxt  = 1'b1;
                    end else begin
                        en_nxt  = 1'b1;
                        vel_nxt = overflow ? MAX_V : vel_inc_sat;
                    end
                end
                default: begin
                    state_nxt = GROUND;
                    vel_nxt   = '0;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign vel_y     = vel_q;
    assign pure_grav = (state_q == APEX);
    assign count_en  = en_q;
    assign cnt_clr   = clr_q;
    assign jump_ack  = ack_q;
    assign landed    = land_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// tb_jump_sequencer: directed scenarios for jump_sequencer with
// hand-computed expected state, velocity and pulse values.
module tb_jump_sequencer;

    logic              CLK;
    logic              RESET_N;
    logic              frame_tick;
    logic              jump_req;
    logic              on_ground;
    logic [10:0]       count_in;
    logic              count_en;
    logic              cnt_clr;
    logic              pure_grav;
    logic signed [4:0] vel_y;
    logic [1:0]        state;
    logic              jump_ack;
    logic              landed;

    int checks;
    int errors;
    logic signed [4:0] exp_v;

    jump_sequencer dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .frame_tick (frame_tick),
        .jump_req   (jump_req),
        .on_ground  (on_ground),
        .count_in   (count_in),
        .count_en   (count_en),
        .cnt_clr    (cnt_clr),
        .pure_grav  (pure_grav),
        .vel_y      (vel_y),
        .state      (state),
        .jump_ack   (jump_ack),
        .landed     (landed)
    );

    // clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // one clock with no tick; returns 1 time unit after the edge
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // one frame tick; outputs are observed 1 time unit after its edge
    task automatic tick();
        frame_tick = 1'b1;
        @(posedge CLK);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; frame_tick = 1'b1; jump_req = 1'b1; on_ground = 1'b1; count_in = '0;
        cycle(); cycle();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (vel_y !== 5'sd0) begin errors++; $display("FAIL reset_vel got %0d exp 0", vel_y); end
        checks++; if ({count_en, cnt_clr, jump_ack, landed} !== 4'b0000) begin errors++;
            $display("FAIL reset_pulses got %b exp 0000", {count_en, cnt_clr, jump_ack, landed}); end
        frame_tick = 1'b0; jump_req = 1'b0;
        cycle();
        RESET_N = 1'b1;
        cycle(); cycle();
    endtask

    task automatic test_full_jump();
        on_ground = 1'b1; jump_req = 1'b1;
        cycle(); cycle();          // press captured as pending
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL launch_state got %0d exp 1", state); end
        checks++; if (vel_y !== -5'sd8) begin errors++; $display("FAIL launch_vel got %0d exp -8", vel_y); end
        checks++; if ({cnt_clr, jump_ack, count_en} !== 3'b110) begin errors++;
            $display("FAIL launch_pulses got %b exp 110", {cnt_clr, jump_ack, count_en}); end
        on_ground = 1'b0;
        cycle();
        checks++; if ({cnt_clr, jump_ack} !== 2'b00) begin errors++;
            $display("FAIL launch_pulse_width got %b exp 00", {cnt_clr, jump_ack}); end
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_v = 5'(-8 + i);
            checks++; if (vel_y !== exp_v || state !== 2'd1 || count_en !== 1'b1) begin errors++;
                $display("FAIL rise_step%0d got vel %0d st %0d en %b exp vel %0d st 1 en 1", i, vel_y, state, count_en, exp_v); end
        end
        tick();
        checks++; if (vel_y !== 5'sd0 || state !== 2'd2 || pure_grav !== 1'b1) begin errors++;
            $display("FAIL apex_entry got vel %0d st %0d pg %b exp 0 2 1", vel_y, state, pure_grav); end
        cycle();
        checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL count_en_width got %b exp 0", count_en); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (state !== 2'd2 || pure_grav !== 1'b1 || vel_y !== 5'sd0) begin errors++;
                $display("FAIL apex_hold%0d got st %0d pg %b vel %0d exp 2 1 0", i, state, pure_grav, vel_y); end
        end
        tick();
        checks++; if (state !== 2'd3 || vel_y !== 5'sd1 || pure_grav !== 1'b0) begin errors++;
            $display("FAIL fall_entry got st %0d vel %0d pg %b exp 3 1 0", state, vel_y, pure_grav); end
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_v = (i + 2 > 8) ? 5'sd8 : 5'(i + 2);
            checks++; if (vel_y !== exp_v || state !== 2'd3 || count_en !== 1'b1) begin errors++;
                $display("FAIL fall_step%0d got vel %0d st %0d en %b exp vel %0d st 3 en 1", i, vel_y, state, count_en, exp_v); end
        end
    endtask

    task automatic test_press_in_fall();
        jump_req = 1'b0; cycle();
        jump_req = 1'b1; cycle();   // press while airborne must be dropped
        on_ground = 1'b1;
        tick();
        checks++; if (state !== 2'd0 || vel_y !== 5'sd0 || landed !== 1'b1 || count_en !== 1'b0) begin errors++;
            $display("FAIL fall_land got st %0d vel %0d ld %b en %b exp 0 0 1 0", state, vel_y, landed, count_en); end
        cycle();
        checks++; if (landed !== 1'b0) begin errors++; $display("FAIL landed_width got %b exp 0", landed); end
        tick();
        checks++; if (state !== 2'd0 || jump_ack !== 1'b0 || cnt_clr !== 1'b0) begin errors++;
            $display("FAIL no_buffered_launch got st %0d ack %b clr %b exp 0 0 0", state, jump_ack, cnt_clr); end
    endtask

    task automatic test_walk_off_and_landing();
        jump_req = 1'b0; on_ground = 1'b0;
        cycle();
        tick();
        checks++; if (state !== 2'd3 || vel_y !== 5'sd1 || cnt_clr !== 1'b1 || jump_ack !== 1'b0 || count_en !== 1'b0) begin errors++;
            $display("FAIL walk_off got st %0d vel %0d clr %b ack %b en %b exp 3 1 1 0 0", state, vel_y, cnt_clr, jump_ack, count_en); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (vel_y !== 5'sd5) begin errors++; $display("FAIL walk_fall_vel got %0d exp 5", vel_y); end
        on_ground = 1'b1;
        tick();
        checks++; if (state !== 2'd0 || vel_y !== 5'sd0 || landed !== 1'b1 || count_en !== 1'b0) begin errors++;
            $display("FAIL landing got st %0d vel %0d ld %b en %b exp 0 0 1 0", state, vel_y, landed, count_en); end
    endtask

    task automatic test_edge_on_tick_and_early_release();
        jump_req = 1'b0; on_ground = 1'b1;
        cycle(); cycle();
        jump_req = 1'b1;            // edge lands exactly on the tick
        tick();
        checks++; if (state !== 2'd1 || vel_y !== -5'sd8 || jump_ack !== 1'b1) begin errors++;
            $display("FAIL edge_on_tick got st %0d vel %0d ack %b exp 1 -8 1", state, vel_y, jump_ack); end
        on_ground = 1'b0;
        tick(); tick();
        checks++; if (vel_y !== -5'sd6) begin errors++; $display("FAIL pre_release_vel got %0d exp -6", vel_y); end
        jump_req = 1'b0;
        tick();
        checks++; if (vel_y !== -5'sd1 || state !== 2'd1) begin errors++;
            $display("FAIL height_cut got vel %0d st %0d exp -1 1", vel_y, state); end
        tick();
        checks++; if (vel_y !== 5'sd0 || state !== 2'd2) begin errors++;
            $display("FAIL cut_apex got vel %0d st %0d exp 0 2", vel_y, state); end
        count_in = 11'h7FF;
        tick();
        checks++; if (state !== 2'd3 || vel_y !== 5'sd8 || count_en !== 1'b1) begin errors++;
            $display("FAIL apex_overflow got st %0d vel %0d en %b exp 3 8 1", state, vel_y, count_en); end
        count_in = '0; on_ground = 1'b1;
        tick();
    endtask

    task automatic test_rise_overflow();
        jump_req = 1'b0; on_ground = 1'b1;
        cycle();
        jump_req = 1'b1; cycle();
        tick();
        on_ground = 1'b0;
        tick();
        checks++; if (vel_y !== -5'sd7 || state !== 2'd1) begin errors++;
            $display("FAIL ovf_pre got vel %0d st %0d exp -7 1", vel_y, state); end
        count_in = 11'h7FF;
        tick();
        checks++; if (state !== 2'd3 || vel_y !== 5'sd8 || count_en !== 1'b1) begin errors++;
            $display("FAIL rise_overflow got st %0d vel %0d en %b exp 3 8 1", state, vel_y, count_en); end
        on_ground = 1'b1;
        tick();
        checks++; if (state !== 2'd0 || vel_y !== 5'sd0 || landed !== 1'b1) begin errors++;
            $display("FAIL land_beats_overflow got st %0d vel %0d ld %b exp 0 0 1", state, vel_y, landed); end
        count_in = '0;
    endtask

    task automatic test_async_reset_mid_rise();
        jump_req = 1'b0; on_ground = 1'b1;
        cycle();
        jump_req = 1'b1;
        tick();
        on_ground = 1'b0;
        tick(); tick(); tick();
        checks++; if (vel_y !== -5'sd5 || count_en !== 1'b1) begin errors++;
            $display("FAIL pre_reset got vel %0d en %b exp -5 1", vel_y, count_en); end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || vel_y !== 5'sd0) begin errors++;
            $display("FAIL async_reset got st %0d vel %0d exp 0 0", state, vel_y); end
        checks++; if ({count_en, cnt_clr, jump_ack, landed} !== 4'b0000) begin errors++;
            $display("FAIL async_reset_pulses got %b exp 0000", {count_en, cnt_clr, jump_ack, landed}); end
        cycle();
        RESET_N = 1'b1;
        cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_jump();
        test_press_in_fall();
        test_walk_off_and_landing();
        test_edge_on_tick_and_early_release();
        test_rise_overflow();
        test_async_reset_mid_rise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
